// File: rtl/sad_disparity_search.sv
`default_nettype none
// ============================================================================
// Module   : sad_disparity_search
// Purpose  : Streaming stereo block matcher; returns the min-SAD disparity.
// Revision : 1.0 - initial release
// ============================================================================
module sad_disparity_search #(
    parameter  int PIX_W    = 8,
    parameter  int WIN      = 9,
    parameter  int MAX_DISP = 64,
    localparam int DISP_W   = $clog2(MAX_DISP),
    localparam int SAD_W    = PIX_W + $clog2(WIN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_left_valid,
    output logic                   o_left_ready,
    input  logic [WIN*PIX_W-1:0]   i_left_win,
    input  logic                   i_cand_valid,
    output logic                   o_cand_ready,
    input  logic [WIN*PIX_W-1:0]   i_cand_win,
    input  logic                   i_cand_last,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [DISP_W-1:0]      o_res_disp,
    output logic [SAD_W-1:0]       o_res_sad,
    output logic                   o_res_trunc
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    logic [1:0]            r_state;
    logic [WIN*PIX_W-1:0]  r_left;
    logic [DISP_W-1:0]     r_idx;

    logic [PIX_W-1:0]      r_diff [WIN];
    logic                  r_s1_vld;
    logic [DISP_W-1:0]     r_s1_disp;
    logic                  r_s1_first;
    logic                  r_s1_last;
    logic                  r_s1_trunc;

    logic                  r_s2_vld;
    logic [SAD_W-1:0]      r_s2_sum;
    logic [DISP_W-1:0]     r_s2_disp;
    logic                  r_s2_first;
    logic                  r_s2_last;
    logic                  r_s2_trunc;

    logic [SAD_W-1:0]      r_min_sad;
    logic [DISP_W-1:0]     r_min_disp;
    logic [SAD_W-1:0]      r_res_sad;
    logic [DISP_W-1:0]     r_res_disp;
    logic                  r_res_trunc;

    logic                  w_cand_acc;
    logic                  w_idx_max;
    logic                  w_cand_end;
    logic                  w_trunc;
    logic [PIX_W-1:0]      w_diff [WIN];
    logic [SAD_W-1:0]      w_sum;
    logic                  w_take;
    logic [SAD_W-1:0]      w_best_sad;
    logic [DISP_W-1:0]     w_best_disp;

    assign o_left_ready = (r_state == S_IDLE);
    assign o_cand_ready = (r_state == S_SEARCH);
    assign o_res_valid  = (r_state == S_RESULT);
    assign o_res_disp   = r_res_disp;
    assign o_res_sad    = r_res_sad;
    assign o_res_trunc  = r_res_trunc;

    assign w_cand_acc = i_cand_valid && (r_state == S_SEARCH);
    assign w_idx_max  = (r_idx == DISP_W'(MAX_DISP - 1));
    assign w_cand_end = i_cand_last || w_idx_max;
    assign w_trunc    = w_idx_max && !i_cand_last;

    for (genvar gi = 0; gi < WIN; gi++) begin : g_absdiff
        logic [PIX_W-1:0] w_l;
        logic [PIX_W-1:0] w_c;
        assign w_l        = r_left[gi*PIX_W +: PIX_W];
        assign w_c        = i_cand_win[gi*PIX_W +: PIX_W];
        assign w_diff[gi] = (w_l >= w_c) ? (w_l - w_c) : (w_c - w_l);
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < WIN; i++) begin
            w_sum = w_sum + SAD_W'(r_diff[i]);
        end
    end

    // First result of a search always loads; strict less-than keeps the lower disparity on ties.
    assign w_take      = r_s2_first || (r_s2_sum < r_min_sad);
    assign w_best_sad  = w_take ? r_s2_sum  : r_min_sad;
    assign w_best_disp = w_take ? r_s2_disp : r_min_disp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_left      <= '0;
            r_idx       <= '0;
            for (int i = 0; i < WIN; i++) begin
                r_diff[i] <= '0;
            end
            r_s1_vld    <= 1'b0;
            r_s1_disp   <= '0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_trunc  <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_s2_sum    <= '0;
            r_s2_disp   <= '0;
            r_s2_first  <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_trunc  <= 1'b0;
            r_min_sad   <= '0;
            r_min_disp  <= '0;
            r_res_sad   <= '0;
            r_res_disp  <= '0;
            r_res_trunc <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_left_valid) begin
                        r_left  <= i_left_win;
                        r_idx   <= '0;
                        r_state <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (i_cand_valid) begin
                        r_idx <= r_idx + 1'b1;
                        if (w_cand_end) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_s2_vld && r_s2_last) begin
                        r_state <= S_RESULT;
                    end
                end
                default: begin
                    if (i_res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase

            r_s1_vld <= w_cand_acc;
            if (w_cand_acc) begin
                for (int i = 0; i < WIN; i++) begin
                    r_diff[i] <= w_diff[i];
                end
                r_s1_disp  <= r_idx;
                r_s1_first <= (r_idx == '0);
                r_s1_last  <= w_cand_end;
                r_s1_trunc <= w_trunc;
            end

            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_sum   <= w_sum;
                r_s2_disp  <= r_s1_disp;
                r_s2_first <= r_s1_first;
                r_s2_last  <= r_s1_last;
                r_s2_trunc <= r_s1_trunc;
            end

            if (r_s2_vld) begin
                r_min_sad  <= w_best_sad;
                r_min_disp <= w_best_disp;
                if (r_s2_last) begin
                    r_res_sad   <= w_best_sad;
                    r_res_disp  <= w_best_disp;
                    r_res_trunc <= r_s2_trunc;
                end
            end
        end
    end

endmodule
`default_nettype wire
